traffic_light_monitor: RTL and testbench

//   Receive-side checker for the red/yellow/green light interface driven by the traffic light controller.

---
 rtl/traffic_light_pkg.sv | 50 +++++
 rtl/tl_dwell_timer.sv | 91 +++++++++
 rtl/traffic_light_monitor.sv | 158 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light monitor: phase encodings, error
// bit indices and small decode helpers used by the FSM and the dwell timer.
package traffic_light_pkg;

    // Monitor phase; encoding is visible on the phase output.
    typedef enum logic [1:0] {
        PH_SYNC   = 2'b00,
        PH_RED    = 2'b01,
        PH_GREEN  = 2'b10,
        PH_YELLOW = 2'b11
    } phase_e;

    // Error vector layout shared by err_pulse and err_status.
    localparam int unsigned ERR_W      = 5;
    localparam int unsigned ERR_ONEHOT = 0;
    localparam int unsigned ERR_ORDER  = 1;
    localparam int unsigned ERR_SHORT  = 2;
    localparam int unsigned ERR_LONG   = 3;
    localparam int unsigned ERR_FROZEN = 4;

    // Light vector packing order: {red, green, yellow}.
    localparam int unsigned LIGHT_W = 3;

    // Phase implied by a one-hot light vector; SYNC for anything else.
    function automatic phase_e light_phase(input logic [LIGHT_W-1:0] lights);
        phase_e ph;
        ph = PH_SYNC;
        case (lights)
            3'b100:  ph = PH_RED;
            3'b010:  ph = PH_GREEN;
            3'b001:  ph = PH_YELLOW;
            default: ph = PH_SYNC;
        endcase
        return ph;
    endfunction

    // Legal successor in the R->G->Y->R loop.
    function automatic phase_e legal_next(input phase_e ph);
        phase_e nx;
        nx = PH_SYNC;
        case (ph)
            PH_RED:    nx = PH_GREEN;
            PH_GREEN:  nx = PH_YELLOW;
            PH_YELLOW: nx = PH_RED;
            default:   nx = PH_RED;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Dwell counter for the current light phase plus the MIN/MAX compares.
// Ports:
//   clk, reset_n       clock and async active-low reset
//   phase_i            phase whose limits apply (the phase being left/held)
//   load_i             start a new phase: dwell becomes 1
//   clr_i              drop to SYNC: dwell becomes 0 (wins over load)
//   inc_i              one more enabled cycle in the same phase (saturating)
//   dwell_o            registered dwell count
//   short_o            combinational: dwell below MIN of phase_i
//   long_o             combinational: this increment crosses MAX -> MAX+1
module tl_dwell_timer
    import traffic_light_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RED_MIN    = 4,
    parameter int unsigned RED_MAX    = 8,
    parameter int unsigned GREEN_MIN  = 4,
    parameter int unsigned GREEN_MAX  = 8,
    parameter int unsigned YELLOW_MIN = 2,
    parameter int unsigned YELLOW_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  phase_e           phase_i,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] dwell_o,
    output logic             short_o,
    output logic             long_o
);

    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] dwell_d;
    logic [CNT_W-1:0] min_sel;
    logic [CNT_W-1:0] max_sel;
    logic             sat;

    // Limits of the phase currently held; SYNC has no limits.
    always_comb begin
        min_sel = '0;
        max_sel = '0;
        case (phase_i)
            PH_RED: begin
                min_sel = CNT_W'(RED_MIN);
                max_sel = CNT_W'(RED_MAX);
            end
            PH_GREEN: begin
                min_sel = CNT_W'(GREEN_MIN);
                max_sel = CNT_W'(GREEN_MAX);
            end
            PH_YELLOW: begin
                min_sel = CNT_W'(YELLOW_MIN);
                max_sel = CNT_W'(YELLOW_MAX);
            end
            default: begin
                min_sel = '0;
                max_sel = '0;
            end
        endcase
    end

    assign sat = (dwell_q == {CNT_W{1'b1}});

    // A MAX of zero disables the check; a saturated counter cannot cross MAX.
    assign short_o = (dwell_q < min_sel);
    assign long_o  = inc_i && (max_sel != '0) && (dwell_q == max_sel) && !sat;

    // Next dwell value: clear beats load beats increment.
    always_comb begin
        dwell_d = dwell_q;
        if (clr_i) begin
            dwell_d = '0;
        end else if (load_i) begin
            dwell_d = CNT_W'(1);
        end else if (inc_i && !sat) begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    assign dwell_o = dwell_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the red/yellow/green light interface. Tracks the
// current phase and its dwell, and flags bad encodings, bad sequences, dwell
// violations and light changes while the controller is disabled.
// Ports:
//   clk, reset_n       clock and async active-low reset
//   enable             controller enable; dwell advances only when high
//   red/yellow/green   light lines, synchronous to clk
//   clr_err            synchronous clear of err_status (new errors win)
//   phase              00 SYNC, 01 RED, 10 GREEN, 11 YELLOW
//   dwell              enabled cycles spent in the current phase
//   err_pulse          one-cycle error pulses {FROZEN,LONG,SHORT,ORDER,ONEHOT}
//   err_status         sticky OR of err_pulse
//   cycle_count        legal Y->R completions, wrapping
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned RED_MIN    = 4,
    parameter int unsigned RED_MAX    = 8,
    parameter int unsigned GREEN_MIN  = 4,
    parameter int unsigned GREEN_MAX  = 8,
    parameter int unsigned YELLOW_MIN = 2,
    parameter int unsigned YELLOW_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic [ERR_W-1:0] err_pulse,
    output logic [ERR_W-1:0] err_status,
    output logic [CYC_W-1:0] cycle_count
);

    phase_e               phase_q;
    phase_e               phase_d;
    logic [ERR_W-1:0]     err_pulse_q;
    logic [ERR_W-1:0]     err_pulse_d;
    logic [ERR_W-1:0]     err_status_q;
    logic [ERR_W-1:0]     err_status_d;
    logic [CYC_W-1:0]     cycle_q;
    logic [CYC_W-1:0]     cycle_d;
    logic [LIGHT_W-1:0]   lights_q;
    logic                 lights_vld_q;

    logic [LIGHT_W-1:0]   lights;
    logic                 onehot;
    phase_e               light_ph;
    logic                 light_changed;

    logic                 dw_load;
    logic                 dw_clr;
    logic                 dw_inc;
    logic                 dw_short;
    logic                 dw_long;

    assign lights   = {red, green, yellow};
    assign onehot   = $onehot(lights);
    assign light_ph = light_phase(lights);

    // lights_vld_q masks the first sample after reset, when there is no
    // previous value to compare against.
    assign light_changed = lights_vld_q && (lights != lights_q);

    tl_dwell_timer #(
        .CNT_W      (CNT_W),
        .RED_MIN    (RED_MIN),
        .RED_MAX    (RED_MAX),
        .GREEN_MIN  (GREEN_MIN),
        .GREEN_MAX  (GREEN_MAX),
        .YELLOW_MIN (YELLOW_MIN),
        .YELLOW_MAX (YELLOW_MAX)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .phase_i (phase_q),
        .load_i  (dw_load),
        .clr_i   (dw_clr),
        .inc_i   (dw_inc),
        .dwell_o (dwell),
        .short_o (dw_short),
        .long_o  (dw_long)
    );

    // Phase FSM, error detection and cycle counting.
    always_comb begin
        phase_d      = phase_q;
        err_pulse_d  = '0;
        cycle_d      = cycle_q;
        dw_load      = 1'b0;
        dw_clr       = 1'b0;
        dw_inc       = 1'b0;

        if (!onehot) begin
            // Invalid encoding drops back to SYNC every cycle it persists.
            err_pulse_d[ERR_ONEHOT] = 1'b1;
            phase_d                 = PH_SYNC;
            dw_clr                  = 1'b1;
        end else if (phase_q == PH_SYNC) begin
            // Only a clean red starts tracking; green/yellow just wait.
            if (light_ph == PH_RED) begin
                phase_d = PH_RED;
                dw_load = 1'b1;
            end
        end else if (light_ph == phase_q) begin
            dw_inc                = enable;
            err_pulse_d[ERR_LONG] = dw_long;
        end else if (light_ph == legal_next(phase_q)) begin
            err_pulse_d[ERR_SHORT] = dw_short;
            phase_d                = light_ph;
            dw_load                = 1'b1;
            if (phase_q == PH_YELLOW) begin
                cycle_d = cycle_q + CYC_W'(1);
            end
        end else begin
            // Out-of-order light: resync without judging the old dwell.
            err_pulse_d[ERR_ORDER] = 1'b1;
            phase_d                = light_ph;
            dw_load                = 1'b1;
        end

        if (!enable && light_changed) begin
            err_pulse_d[ERR_FROZEN] = 1'b1;
        end

        // A fresh error survives a simultaneous clear.
        err_status_d = clr_err ? err_pulse_d : (err_status_q | err_pulse_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= PH_SYNC;
            err_pulse_q  <= '0;
            err_status_q <= '0;
            cycle_q      <= '0;
            lights_q     <= '0;
            lights_vld_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            err_pulse_q  <= err_pulse_d;
            err_status_q <= err_status_d;
            cycle_q      <= cycle_d;
            lights_q     <= lights;
            lights_vld_q <= 1'b1;
        end
    end

    assign phase       = phase_q;
    assign err_pulse   = err_pulse_q;
    assign err_status  = err_status_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned CYC_W = 16;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic             red;
    logic             yellow;
    logic             green;
    logic             clr_err;
    logic [1:0]       phase;
    logic [CNT_W-1:0] dwell;
    logic [4:0]       err_pulse;
    logic [4:0]       err_status;
    logic [CYC_W-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_monitor #(
        .CNT_W      (CNT_W),
        .CYC_W      (CYC_W),
        .RED_MIN    (4),
        .RED_MAX    (8),
        .GREEN_MIN  (4),
        .GREEN_MAX  (8),
        .YELLOW_MIN (2),
        .YELLOW_MAX (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .clr_err     (clr_err),
        .phase       (phase),
        .dwell       (dwell),
        .err_pulse   (err_pulse),
        .err_status  (err_status),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic g, input logic y,
                        input logic en, input logic clr);
        red     = r;
        green   = g;
        yellow  = y;
        enable  = en;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        n_checks++; if (phase !== 2'b00) begin n_fail++; $display("FAIL reset_phase: got %b expected 00", phase); end
        n_checks++; if (dwell !== 8'd0) begin n_fail++; $display("FAIL reset_dwell: got %0d expected 0", dwell); end
        n_checks++; if (err_pulse !== 5'b0 || err_status !== 5'b0) begin n_fail++; $display("FAIL reset_err: got pulse %b status %b expected 0", err_pulse, err_status); end
        n_checks++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d expected 0", cycle_count); end
        reset_n = 1'b1;
        step(1, 0, 0, 1, 0);
        n_checks++; if (phase !== 2'b01 || dwell !== 8'd1) begin n_fail++; $display("FAIL sync_to_red: got phase %b dwell %0d expected 01/1", phase, dwell); end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        n_checks++; if (phase !== 2'b01 || dwell !== 8'd5) begin n_fail++; $display("FAIL red_dwell5: got phase %b dwell %0d expected 01/5", phase, dwell); end
        n_checks++; if (err_status !== 5'b0) begin n_fail++; $display("FAIL red_no_err: got %b expected 00000", err_status); end
    endtask

    task automatic test_legal_loop();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0);
        n_checks++; if (phase !== 2'b10 || dwell !== 8'd5) begin n_fail++; $display("FAIL green_dwell5: got phase %b dwell %0d expected 10/5", phase, dwell); end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        n_checks++; if (phase !== 2'b11 || dwell !== 8'd3) begin n_fail++; $display("FAIL yellow_dwell3: got phase %b dwell %0d expected 11/3", phase, dwell); end
        step(1, 0, 0, 1, 0);
        n_checks++; if (cycle_count !== 16'd1) begin n_fail++; $display("FAIL loop_cycles: got %0d expected 1", cycle_count); end
        n_checks++; if (phase !== 2'b01 || dwell !== 8'd1) begin n_fail++; $display("FAIL loop_red: got phase %b dwell %0d expected 01/1", phase, dwell); end
        n_checks++; if (err_status !== 5'b0) begin n_fail++; $display("FAIL loop_no_err: got %b expected 00000", err_status); end
    endtask

    task automatic test_long_short();
        for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 0);
        n_checks++; if (dwell !== 8'd8 || err_pulse !== 5'b0) begin n_fail++; $display("FAIL long_pre: got dwell %0d pulse %b expected 8/00000", dwell, err_pulse); end
        step(1, 0, 0, 1, 0);
        n_checks++; if (err_pulse !== 5'b01000 || dwell !== 8'd9) begin n_fail++; $display("FAIL long_pulse: got pulse %b dwell %0d expected 01000/9", err_pulse, dwell); end
        n_checks++; if (err_status !== 5'b01000) begin n_fail++; $display("FAIL long_status: got %b expected 01000", err_status); end
        step(1, 0, 0, 1, 0);
        n_checks++; if (err_pulse !== 5'b0 || dwell !== 8'd10) begin n_fail++; $display("FAIL long_once: got pulse %b dwell %0d expected 00000/10", err_pulse, dwell); end
        step(0, 1, 0, 1, 0);
        n_checks++; if (err_pulse !== 5'b0) begin n_fail++; $display("FAIL long_exit_no_short: got %b expected 00000", err_pulse); end
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        n_checks++; if (cycle_count !== 16'd2 || dwell !== 8'd2) begin n_fail++; $display("FAIL short_setup: got cycles %0d dwell %0d expected 2/2", cycle_count, dwell); end
        step(0, 1, 0, 1, 0);
        n_checks++; if (err_pulse !== 5'b00100 || phase !== 2'b10) begin n_fail++; $display("FAIL short_pulse: got pulse %b phase %b expected 00100/10", err_pulse, phase); end
        n_checks++; if (err_status !== 5'b01100) begin n_fail++; $display("FAIL short_status: got %b expected 01100", err_status); end
    endtask

    task automatic test_order();
        step(0, 1, 0, 1, 1);
        n_checks++; if (err_status !== 5'b0 || dwell !== 8'd2) begin n_fail++; $display("FAIL clr_plain: got status %b dwell %0d expected 00000/2", err_status, dwell); end
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        n_checks++; if (cycle_count !== 16'd3 || err_pulse !== 5'b0) begin n_fail++; $display("FAIL order_setup: got cycles %0d pulse %b expected 3/00000", cycle_count, err_pulse); end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        n_checks++; if (err_pulse !== 5'b00010) begin n_fail++; $display("FAIL order_pulse: got %b expected 00010", err_pulse); end
        n_checks++; if (phase !== 2'b11 || dwell !== 8'd1) begin n_fail++; $display("FAIL order_resync: got phase %b dwell %0d expected 11/1", phase, dwell); end
        step(0, 0, 1, 1, 0);
        n_checks++; if (err_pulse !== 5'b0 || dwell !== 8'd2) begin n_fail++; $display("FAIL order_once: got pulse %b dwell %0d expected 00000/2", err_pulse, dwell); end
    endtask

    task automatic test_onehot();
        step(1, 1, 0, 1, 0);
        n_checks++; if (err_pulse !== 5'b00001 || phase !== 2'b00 || dwell !== 8'd0) begin n_fail++; $display("FAIL onehot_first: got pulse %b phase %b dwell %0d expected 00001/00/0", err_pulse, phase, dwell); end
        step(1, 1, 0, 1, 0);
        n_checks++; if (err_pulse !== 5'b00001 || phase !== 2'b00) begin n_fail++; $display("FAIL onehot_repeat: got pulse %b phase %b expected 00001/00", err_pulse, phase); end
        n_checks++; if (err_status !== 5'b00011) begin n_fail++; $display("FAIL onehot_status: got %b expected 00011", err_status); end
        step(1, 0, 0, 1, 0);
        n_checks++; if (phase !== 2'b01 || dwell !== 8'd1 || err_pulse !== 5'b0) begin n_fail++; $display("FAIL onehot_recover: got phase %b dwell %0d pulse %b expected 01/1/00000", phase, dwell, err_pulse); end
    endtask

    task automatic test_frozen_clear();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
        n_checks++; if (phase !== 2'b10 || dwell !== 8'd4 || err_pulse !== 5'b0) begin n_fail++; $display("FAIL frozen_setup: got phase %b dwell %0d pulse %b expected 10/4/00000", phase, dwell, err_pulse); end
        step(0, 0, 1, 0, 0);
        n_checks++; if (err_pulse !== 5'b10000) begin n_fail++; $display("FAIL frozen_pulse: got %b expected 10000", err_pulse); end
        n_checks++; if (phase !== 2'b11 || dwell !== 8'd1) begin n_fail++; $display("FAIL frozen_phase: got phase %b dwell %0d expected 11/1", phase, dwell); end
        step(0, 0, 1, 0, 0);
        n_checks++; if (dwell !== 8'd1 || err_pulse !== 5'b0) begin n_fail++; $display("FAIL frozen_hold: got dwell %0d pulse %b expected 1/00000", dwell, err_pulse); end
        n_checks++; if (err_status !== 5'b10011) begin n_fail++; $display("FAIL frozen_status: got %b expected 10011", err_status); end
        step(0, 0, 1, 0, 1);
        n_checks++; if (err_status !== 5'b0) begin n_fail++; $display("FAIL clr_idle: got %b expected 00000", err_status); end
        step(0, 1, 0, 1, 1);
        n_checks++; if (err_status !== 5'b00010 || err_pulse !== 5'b00010) begin n_fail++; $display("FAIL clr_vs_new: got status %b pulse %b expected 00010/00010", err_status, err_pulse); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        n_checks++; if (phase !== 2'b10 || dwell !== 8'd3) begin n_fail++; $display("FAIL mid_setup: got phase %b dwell %0d expected 10/3", phase, dwell); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (phase !== 2'b00 || dwell !== 8'd0 || err_status !== 5'b0 || cycle_count !== 16'd0) begin n_fail++; $display("FAIL mid_async: got phase %b dwell %0d status %b cycles %0d expected all 0", phase, dwell, err_status, cycle_count); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(1, 0, 0, 1, 0);
        n_checks++; if (phase !== 2'b01 || dwell !== 8'd1 || err_pulse !== 5'b0) begin n_fail++; $display("FAIL mid_restart: got phase %b dwell %0d pulse %b expected 01/1/00000", phase, dwell, err_pulse); end
        step(1, 0, 0, 0, 0);
        n_checks++; if (dwell !== 8'd1 || err_pulse !== 5'b0) begin n_fail++; $display("FAIL mid_disabled_hold: got dwell %0d pulse %b expected 1/00000", dwell, err_pulse); end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        red     = 1'b1;
        green   = 1'b0;
        yellow  = 1'b0;
        clr_err = 1'b0;
        test_reset();
        test_legal_loop();
        test_long_short();
        test_order();
        test_onehot();
        test_frozen_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
